// File: rtl/decode_queue_pkg.sv
// Shared ISA constants, opcode enum and decoded-instruction record for decode_queue.
// DECODE_SYSTEM_EN adds the SYSTEM and MISC_MEM opcodes.
package decode_queue_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef enum logic [3:0] {
      OPCODE_LUI,
      OPCODE_AUIPC,
      OPCODE_JAL,
      OPCODE_JALR,
      OPCODE_BRANCH,
      OPCODE_LOAD,
      OPCODE_STORE,
      OPCODE_OP_IMM,
      OPCODE_OP,
`ifdef DECODE_SYSTEM_EN
      OPCODE_SYSTEM,
      OPCODE_MISC_MEM,
`endif
      OPCODE_UNKNOWN
   } opcode_t;

   typedef struct packed {
      opcode_t         opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] i_imm;
      logic [XLEN-1:0] s_imm;
      logic [XLEN-1:0] b_imm;
      logic [XLEN-1:0] u_imm;
      logic [XLEN-1:0] j_imm;
   } decoded_instruction_t;

   typedef struct packed {
      decoded_instruction_t dec;
      logic [XLEN-1:0]      pc;
      logic                 illegal;
   } fifo_entry_t;

   function automatic opcode_t opcode_of(input logic [6:0] opc);
      opcode_t o;
      unique case (opc)
         OPC_LUI:      o = OPCODE_LUI;
         OPC_AUIPC:    o = OPCODE_AUIPC;
         OPC_JAL:      o = OPCODE_JAL;
         OPC_JALR:     o = OPCODE_JALR;
         OPC_BRANCH:   o = OPCODE_BRANCH;
         OPC_LOAD:     o = OPCODE_LOAD;
         OPC_STORE:    o = OPCODE_STORE;
         OPC_OP_IMM:   o = OPCODE_OP_IMM;
         OPC_OP:       o = OPCODE_OP;
`ifdef DECODE_SYSTEM_EN
         OPC_SYSTEM:   o = OPCODE_SYSTEM;
         OPC_MISC_MEM: o = OPCODE_MISC_MEM;
`endif
         default:      o = OPCODE_UNKNOWN;
      endcase
      return o;
   endfunction

   function automatic decoded_instruction_t decode_fields(
      input logic [ILEN-1:0] i
   );
      decoded_instruction_t d;
      d.opcode = opcode_of(i[6:0]);
      d.rd     = i[11:7];
      d.rs1    = i[19:15];
      d.rs2    = i[24:20];
      d.funct3 = i[14:12];
      d.funct7 = i[31:25];
      d.i_imm  = XLEN'($signed(i[31:20]));
      d.s_imm  = XLEN'($signed({i[31:25], i[11:7]}));
      d.b_imm  = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      d.u_imm  = XLEN'($signed({i[31:12], 12'b0}));
      d.j_imm  = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      return d;
   endfunction

endpackage

// File: rtl/decode_legality_check.sv
// Combinational illegal-encoding detector, shared with the trap logic.
// DECODE_SYSTEM_EN makes SYSTEM (funct3 = 0) and MISC_MEM legal.
module decode_legality_check
   import decode_queue_pkg::*;
(
   input  logic [ILEN-1:0] instr,
   output logic            illegal
);

   logic [2:0] f3;
   logic [6:0] f7;
   logic       unused_bits;

   assign f3 = instr[14:12];
   assign f7 = instr[31:25];
   assign unused_bits = ^{instr[24:15], instr[11:7]};

   always_comb begin
      illegal = 1'b0;
      unique case (opcode_of(instr[6:0]))
         OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL: illegal = 1'b0;
         OPCODE_JALR:   illegal = (f3 != 3'b000);
         OPCODE_BRANCH: illegal = f3 inside {3'b010, 3'b011};
         OPCODE_LOAD:   illegal = f3 inside {3'b011, 3'b110, 3'b111};
         OPCODE_STORE:  illegal = (f3 >= 3'b011);
         OPCODE_OP:
            illegal = !(f7 inside {F7_ZERO, F7_ALT}) ||
                      ((f7 == F7_ALT) && !(f3 inside {F3_ADD_SUB, F3_SR}));
         OPCODE_OP_IMM:
            illegal = ((f3 == F3_SLL) && (f7 != F7_ZERO)) ||
                      ((f3 == F3_SR) && !(f7 inside {F7_ZERO, F7_ALT}));
`ifdef DECODE_SYSTEM_EN
         OPCODE_SYSTEM:   illegal = (f3 != 3'b000);
         OPCODE_MISC_MEM: illegal = 1'b0;
`endif
         default: illegal = 1'b1;
      endcase
      if (instr[1:0] != 2'b11) illegal = 1'b1;
   end

endmodule

// File: rtl/decode_queue.sv
// Decode stage with a DEPTH-entry FIFO between fetch and execute; flush drops everything.
// DECODE_SYSTEM_EN enables SYSTEM/MISC_MEM decode in the package and legality check.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ILEN-1:0]      in_instr,
   input  logic [XLEN-1:0]      in_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output decoded_instruction_t out_decoded,
   output logic [XLEN-1:0]      out_pc,
   output logic                 out_illegal
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
      $error("decode_queue: DEPTH must be a power of two >= 2");
   end

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   fifo_entry_t   mem_q [DEPTH];
   fifo_entry_t   mem_d [DEPTH];

   decoded_instruction_t dec;
   logic                 illegal;
   logic                 push;
   logic                 pop;

   decode_legality_check u_legal (
      .instr   (in_instr),
      .illegal (illegal)
   );

   always_comb begin
      dec = decode_fields(in_instr);
      if (illegal) dec.opcode = OPCODE_UNKNOWN;
   end

   assign in_ready  = (count_q < CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = '{dec: dec, pc: in_pc, illegal: illegal};
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is intentionally unreset; out_valid gates its use.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign out_decoded = mem_q[rd_ptr_q].dec;
   assign out_pc      = mem_q[rd_ptr_q].pc;
   assign out_illegal = mem_q[rd_ptr_q].illegal;

endmodule
